// File: rtl/mem_load_ctrl_pkg.sv
// Shared types and constants for the data-memory load sequencer.
// Size codes follow the cpu-wide BYTE/HALF_WORD/WORD encodings with DOUBLE as the fourth code.
package mem_load_ctrl_pkg;

    localparam int unsigned ROW_BYTES = 8;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10,
        DOUBLE    = 2'b11
    } ld_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        RSP0  = 3'd2,
        REQ1  = 3'd3,
        RSP1  = 3'd4,
        DONE  = 3'd5,
        DRAIN = 3'd6
    } load_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            BYTE:      n = 4'd1;
            HALF_WORD: n = 4'd2;
            WORD:      n = 4'd4;
            DOUBLE:    n = 4'd8;
            default:   n = 4'd8;
        endcase
        return n;
    endfunction

    // An access needs a second row when its last byte lies past the end of the first row.
    function automatic logic crosses_row(input logic [2:0] offset, input logic [1:0] size);
        return ({1'b0, offset} + size_bytes(size)) > 4'(ROW_BYTES);
    endfunction

endpackage

// File: rtl/mem_load_ctrl_row_merge.sv
// Combinational merge of two consecutive memory rows: low 64 bits of {row1,row0} >> 8*offset.
module load_row_merge (
    input  logic [63:0] row0,
    input  logic [63:0] row1,
    input  logic [2:0]  offset,
    output logic [63:0] merged
);

    logic [5:0] sh_s;
    logic [6:0] up_sh_s;

    assign sh_s    = {offset, 3'b000};
    // At offset 0 the upper shift is 64, which yields zero and leaves row0 untouched.
    assign up_sh_s = 7'd64 - {1'b0, sh_s};
    assign merged  = (row0 >> sh_s) | (row1 << up_sh_s);

endmodule

// File: rtl/mem_load_ctrl.sv
// Load-path sequencer: issues one or two aligned row reads per load, merges split rows,
// and hands the raw row plus size/extension/offset controls to writeback.
module mem_load_ctrl
    import mem_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [63:0] ld_addr_i,
    input  logic [1:0]  ld_byte_en_i,
    input  logic        ld_zero_extnd_i,
    input  logic [4:0]  ld_rd_idx_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [63:0] mem_req_addr_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_rsp_valid_i,
    input  logic [63:0] mem_rsp_data_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [63:0] wb_data_o,
    output logic [1:0]  wb_byte_en_o,
    output logic        wb_zero_extnd_o,
    output logic [2:0]  wb_row_idx_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic        stall_o
);

    load_state_t state_r;
    load_state_t state_s;

    logic        ld_ready_r;
    logic        stall_r;
    logic        mem_req_r;
    logic        wb_valid_r;
    logic [63:0] mem_req_addr_r;

    logic [63:0] addr_r;
    logic [1:0]  size_r;
    logic        zext_r;
    logic [4:0]  rd_r;
    logic        split_r;
    logic [63:0] row0_r;

    logic [63:0] wb_data_r;
    logic [1:0]  wb_byte_en_r;
    logic        wb_zext_r;
    logic [2:0]  wb_row_idx_r;
    logic [4:0]  wb_rd_idx_r;

    logic        accept_s;
    logic        row0_cap_s;
    logic        enter_req1_s;
    logic        enter_done_s;
    logic [63:0] merged_s;

    // Next-state logic; a flush with a handshake or response in the same cycle decides drain vs. idle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ld_valid_i && !flush_i) state_s = REQ0;
                else                        state_s = IDLE;
            end
            REQ0, REQ1: begin
                if (flush_i) begin
                    if (mem_req_ready_i) state_s = DRAIN;
                    else                 state_s = IDLE;
                end else if (mem_req_ready_i) begin
                    state_s = (state_r == REQ0) ? RSP0 : RSP1;
                end else begin
                    state_s = state_r;
                end
            end
            RSP0, RSP1: begin
                if (flush_i) begin
                    if (mem_rsp_valid_i) state_s = IDLE;
                    else                 state_s = DRAIN;
                end else if (mem_rsp_valid_i) begin
                    state_s = (state_r == RSP0 && split_r) ? REQ1 : DONE;
                end else begin
                    state_s = state_r;
                end
            end
            DONE: begin
                if (flush_i || wb_ready_i) state_s = IDLE;
                else                       state_s = DONE;
            end
            DRAIN: begin
                if (mem_rsp_valid_i) state_s = IDLE;
                else                 state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    assign accept_s     = (state_r == IDLE) && (state_s == REQ0);
    assign row0_cap_s   = (state_r == RSP0) && ((state_s == REQ1) || (state_s == DONE));
    assign enter_req1_s = (state_r == RSP0) && (state_s == REQ1);
    assign enter_done_s = (state_s == DONE) && (state_r != DONE);

    load_row_merge u_merge (
        .row0   (row0_r),
        .row1   (mem_rsp_data_i),
        .offset (addr_r[2:0]),
        .merged (merged_s)
    );

    // State register plus control outputs decoded from the next state so they leave a flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            ld_ready_r <= 1'b1;
            stall_r    <= 1'b0;
            mem_req_r  <= 1'b0;
            wb_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ld_ready_r <= (state_s == IDLE);
            stall_r    <= (state_s != IDLE);
            mem_req_r  <= (state_s == REQ0) || (state_s == REQ1);
            wb_valid_r <= (state_s == DONE);
        end
    end

    // Load capture, request address, first-row capture and writeback result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_r         <= 64'd0;
            size_r         <= 2'd0;
            zext_r         <= 1'b0;
            rd_r           <= 5'd0;
            split_r        <= 1'b0;
            row0_r         <= 64'd0;
            mem_req_addr_r <= 64'd0;
            wb_data_r      <= 64'd0;
            wb_byte_en_r   <= 2'd0;
            wb_zext_r      <= 1'b0;
            wb_row_idx_r   <= 3'd0;
            wb_rd_idx_r    <= 5'd0;
        end else begin
            if (accept_s) begin
                addr_r         <= ld_addr_i;
                size_r         <= ld_byte_en_i;
                zext_r         <= ld_zero_extnd_i;
                rd_r           <= ld_rd_idx_i;
                split_r        <= crosses_row(ld_addr_i[2:0], ld_byte_en_i);
                mem_req_addr_r <= {ld_addr_i[63:3], 3'b000};
            end
            if (row0_cap_s) begin
                row0_r <= mem_rsp_data_i;
            end
            // Next row address wraps naturally at the top of the address space.
            if (enter_req1_s) begin
                mem_req_addr_r <= {addr_r[63:3], 3'b000} + 64'(ROW_BYTES);
            end
            if (enter_done_s) begin
                wb_byte_en_r <= size_r;
                wb_zext_r    <= zext_r;
                wb_rd_idx_r  <= rd_r;
                if (state_r == RSP0) begin
                    wb_data_r    <= mem_rsp_data_i;
                    wb_row_idx_r <= addr_r[2:0];
                end else begin
                    wb_data_r    <= merged_s;
                    wb_row_idx_r <= 3'd0;
                end
            end
        end
    end

    assign ld_ready_o      = ld_ready_r;
    assign stall_o         = stall_r;
    assign mem_req_o       = mem_req_r;
    assign mem_req_addr_o  = mem_req_addr_r;
    assign wb_valid_o      = wb_valid_r;
    assign wb_data_o       = wb_data_r;
    assign wb_byte_en_o    = wb_byte_en_r;
    assign wb_zero_extnd_o = wb_zext_r;
    assign wb_row_idx_o    = wb_row_idx_r;
    assign wb_rd_idx_o     = wb_rd_idx_r;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Self-checking bench for mem_load_ctrl: directed scenarios plus randomized loads
// checked against a byte-level memory model.
module tb_mem_load_ctrl;

    logic        clk;
    logic        resetn;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [63:0] ld_addr_i;
    logic [1:0]  ld_byte_en_i;
    logic        ld_zero_extnd_i;
    logic [4:0]  ld_rd_idx_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [63:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rsp_data_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [63:0] wb_data_o;
    logic [1:0]  wb_byte_en_o;
    logic        wb_zero_extnd_o;
    logic [2:0]  wb_row_idx_o;
    logic [4:0]  wb_rd_idx_o;
    logic        stall_o;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;

    mem_load_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .ld_valid_i      (ld_valid_i),
        .ld_ready_o      (ld_ready_o),
        .ld_addr_i       (ld_addr_i),
        .ld_byte_en_i    (ld_byte_en_i),
        .ld_zero_extnd_i (ld_zero_extnd_i),
        .ld_rd_idx_i     (ld_rd_idx_i),
        .flush_i         (flush_i),
        .mem_req_o       (mem_req_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_data_o       (wb_data_o),
        .wb_byte_en_o    (wb_byte_en_o),
        .wb_zero_extnd_o (wb_zero_extnd_o),
        .wb_row_idx_o    (wb_row_idx_o),
        .wb_rd_idx_o     (wb_rd_idx_o),
        .stall_o         (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Deterministic memory contents for the randomized loads.
    function automatic logic [63:0] mem_row(input logic [63:0] row_addr);
        return (row_addr * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    task automatic step();
        @(negedge clk);
        lat++;
    endtask

    task automatic accept(input logic [63:0] a, input logic [1:0] sz, input logic zx, input logic [4:0] rd);
        ld_valid_i      = 1'b1;
        ld_addr_i       = a;
        ld_byte_en_i    = sz;
        ld_zero_extnd_i = zx;
        ld_rd_idx_i     = rd;
        lat = 0;
        step();
        ld_valid_i = 1'b0;
        ld_addr_i  = 64'(~a);
    endtask

    // Holds ready low for w cycles (with stray responses that must be ignored), then handshakes.
    task automatic issue_row(input string tag, input logic [63:0] exp_addr, input int w);
        for (int k = 0; k < w; k++) begin
            chk({tag, " req held"}, 64'(mem_req_o), 64'd1);
            chk({tag, " req addr held"}, mem_req_addr_o, exp_addr);
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = {$urandom, $urandom};
            step();
        end
        mem_rsp_valid_i = 1'b0;
        chk({tag, " req"}, 64'(mem_req_o), 64'd1);
        chk({tag, " req addr"}, mem_req_addr_o, exp_addr);
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        chk({tag, " req dropped"}, 64'(mem_req_o), 64'd0);
    endtask

    task automatic respond(input string tag, input logic [63:0] d, input int w);
        for (int k = 0; k < w; k++) begin
            chk({tag, " no wb while waiting"}, 64'(wb_valid_o), 64'd0);
            step();
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = d;
        step();
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] sz,
                           input logic zx, input logic [4:0] rd,
                           input logic [63:0] r0, input logic [63:0] r1,
                           input int rdy_w, input int rsp_w, input int wb_w);
        logic [7:0]  b [16];
        logic [63:0] row0_addr;
        logic [63:0] exp_data;
        logic [2:0]  off;
        logic [2:0]  exp_idx;
        bit          split;
        int          exp_lat;
        off       = a[2:0];
        row0_addr = a - 64'(off);
        split     = (int'(off) + (1 << sz)) > 8;
        for (int j = 0; j < 8; j++) begin
            b[j]     = r0[8*j +: 8];
            b[j + 8] = r1[8*j +: 8];
        end
        for (int i = 0; i < 8; i++) begin
            exp_data[8*i +: 8] = split ? b[int'(off) + i] : b[i];
        end
        exp_idx = split ? 3'd0 : off;
        exp_lat = split ? 5 + 2 * (rdy_w + rsp_w) : 3 + rdy_w + rsp_w;

        chk({tag, " ready before"}, 64'(ld_ready_o), 64'd1);
        accept(a, sz, zx, rd);
        chk({tag, " stall"}, 64'(stall_o), 64'd1);
        issue_row({tag, " row0"}, row0_addr, rdy_w);
        respond({tag, " row0"}, r0, rsp_w);
        if (split) begin
            issue_row({tag, " row1"}, row0_addr + 64'd8, rdy_w);
            respond({tag, " row1"}, r1, rsp_w);
        end
        chk({tag, " wb_valid"}, 64'(wb_valid_o), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " wb_data"}, wb_data_o, exp_data);
        chk({tag, " row_idx"}, 64'(wb_row_idx_o), 64'(exp_idx));
        chk({tag, " byte_en"}, 64'(wb_byte_en_o), 64'(sz));
        chk({tag, " zext"}, 64'(wb_zero_extnd_o), 64'(zx));
        chk({tag, " rd_idx"}, 64'(wb_rd_idx_o), 64'(rd));
        chk({tag, " no req in done"}, 64'(mem_req_o), 64'd0);
        for (int k = 0; k < wb_w; k++) begin
            step();
            chk({tag, " wb_valid held"}, 64'(wb_valid_o), 64'd1);
            chk({tag, " wb_data held"}, wb_data_o, exp_data);
            chk({tag, " row_idx held"}, 64'(wb_row_idx_o), 64'(exp_idx));
        end
        wb_ready_i = 1'b1;
        step();
        wb_ready_i = 1'b0;
        chk({tag, " wb consumed"}, 64'(wb_valid_o), 64'd0);
        chk({tag, " ready after"}, 64'(ld_ready_o), 64'd1);
        chk({tag, " stall after"}, 64'(stall_o), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ld_ready"}, 64'(ld_ready_o), 64'd1);
        chk({tag, " stall"}, 64'(stall_o), 64'd0);
        chk({tag, " mem_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, " mem_req_addr"}, mem_req_addr_o, 64'd0);
        chk({tag, " wb_valid"}, 64'(wb_valid_o), 64'd0);
        chk({tag, " wb_data"}, wb_data_o, 64'd0);
        chk({tag, " wb_ctrl"}, {53'd0, wb_byte_en_o, wb_zero_extnd_o, wb_row_idx_o, wb_rd_idx_o}, 64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rn;
        resetn          = 1'b0;
        ld_valid_i      = 1'b0;
        ld_addr_i       = 64'd0;
        ld_byte_en_i    = 2'd0;
        ld_zero_extnd_i = 1'b0;
        ld_rd_idx_i     = 5'd0;
        flush_i         = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = 64'd0;
        wb_ready_i      = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Aligned WORD and split WORD from the reference scenarios.
        do_load("aligned word", 64'h1004, 2'd2, 1'b0, 5'd3, 64'h1122334455667788, 64'd0, 0, 0, 0);
        do_load("split word", 64'h1006, 2'd2, 1'b1, 5'd9, 64'hAABB000000000000, 64'h000000000000CCDD, 0, 0, 0);
        chk("split word low32", 64'(wb_data_o[31:0]), 64'hCCDDAABB);

        // Backpressure on request and writeback.
        do_load("backpressure", 64'h2010, 2'd3, 1'b0, 5'd17, 64'hDEADBEEFCAFEF00D, 64'd0, 4, 1, 3);

        // Split DOUBLE wrapping to row 0.
        do_load("wrap double", 64'hFFFFFFFFFFFFFFFC, 2'd3, 1'b1, 5'd31,
                64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 0, 0, 0);

        // Flush in RSP0, response arrives two cycles later.
        accept(64'h3000, 2'd2, 1'b0, 5'd1);
        issue_row("flush rsp0", 64'h3000, 0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush rsp0 drain stall", 64'(stall_o), 64'd1);
        chk("flush rsp0 drain not ready", 64'(ld_ready_o), 64'd0);
        step();
        chk("flush rsp0 still draining", 64'(ld_ready_o), 64'd0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 64'h5555;
        step();
        mem_rsp_valid_i = 1'b0;
        chk("flush rsp0 ready after rsp", 64'(ld_ready_o), 64'd1);
        chk("flush rsp0 no wb", 64'(wb_valid_o), 64'd0);
        step();
        chk("flush rsp0 no late wb", 64'(wb_valid_o), 64'd0);

        // Flush in REQ0 without handshake returns straight to idle.
        accept(64'h3100, 2'd0, 1'b0, 5'd2);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush req0 idle", 64'(ld_ready_o), 64'd1);
        chk("flush req0 no req", 64'(mem_req_o), 64'd0);

        // Flush in REQ0 with same-cycle handshake must drain the issued request.
        accept(64'h3200, 2'd0, 1'b0, 5'd2);
        flush_i         = 1'b1;
        mem_req_ready_i = 1'b1;
        step();
        flush_i         = 1'b0;
        mem_req_ready_i = 1'b0;
        chk("flush req0 hs drain", 64'(ld_ready_o), 64'd0);
        chk("flush req0 hs no req", 64'(mem_req_o), 64'd0);
        respond("flush req0 hs", 64'h1234, 1);
        chk("flush req0 hs idle", 64'(ld_ready_o), 64'd1);
        chk("flush req0 hs no wb", 64'(wb_valid_o), 64'd0);

        // Flush in DONE discards the result.
        accept(64'h3300, 2'd1, 1'b0, 5'd4);
        issue_row("flush done", 64'h3300, 0);
        respond("flush done", 64'h9999, 0);
        chk("flush done wb_valid", 64'(wb_valid_o), 64'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush done dropped", 64'(wb_valid_o), 64'd0);
        chk("flush done idle", 64'(ld_ready_o), 64'd1);

        // Flush in RSP1 with a same-cycle response goes straight to idle.
        accept(64'h340F, 2'd1, 1'b0, 5'd5);
        issue_row("flush rsp1", 64'h3408, 0);
        respond("flush rsp1", 64'h1111, 0);
        issue_row("flush rsp1", 64'h3410, 0);
        flush_i         = 1'b1;
        mem_rsp_valid_i = 1'b1;
        step();
        flush_i         = 1'b0;
        mem_rsp_valid_i = 1'b0;
        chk("flush rsp1 idle", 64'(ld_ready_o), 64'd1);
        chk("flush rsp1 no wb", 64'(wb_valid_o), 64'd0);

        // Flush in IDLE blocks a same-cycle load.
        ld_valid_i = 1'b1;
        flush_i    = 1'b1;
        step();
        ld_valid_i = 1'b0;
        flush_i    = 1'b0;
        chk("flush idle not accepted", 64'(ld_ready_o), 64'd1);
        chk("flush idle no req", 64'(mem_req_o), 64'd0);

        // Randomized loads against the byte-level model.
        for (int n = 0; n < 24; n++) begin
            ra = {$urandom, $urandom};
            if (n % 6 == 5) ra[63:4] = '1;
            rn = ra - 64'(ra[2:0]);
            do_load("random", ra, 2'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                    mem_row(rn), mem_row(rn + 64'd8),
                    $urandom_range(2), $urandom_range(2), $urandom_range(2));
        end

        // Async reset while waiting in RSP1.
        accept(64'h4007, 2'd1, 1'b1, 5'd7);
        issue_row("reset rsp1", 64'h4000, 0);
        respond("reset rsp1", 64'hABCD, 0);
        issue_row("reset rsp1", 64'h4008, 0);
        chk("reset rsp1 stall before", 64'(stall_o), 64'd1);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post reset ready", 64'(ld_ready_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_load_ctrl.md
# mem_load_ctrl

Sequencer for the load path of the data memory. Accepts one load from the execute/memory stage, issues one or two 8-byte-aligned row reads with a req/ready handshake, and merges the rows when the access crosses a row boundary. It then presents the raw row plus byte-enable, extension and row-index controls to the writeback stage, so writeback's shift and extend logic produces the final register value. It also stalls upstream while a load is in flight and cleanly drains outstanding responses on a pipeline flush.

## Interface
- No parameters; widths fixed: XLEN 64, row 8 bytes, 5-bit register index.
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- ld_valid_i  in  1  load request from pipeline
- ld_ready_o  out  1  controller idle, can accept; high exactly when state==IDLE
- ld_addr_i  in  64  byte address
- ld_byte_en_i  in  2  access size (BYTE/HALF_WORD/WORD/DOUBLE from cpu_consts)
- ld_zero_extnd_i  in  1  extension select, forwarded unchanged
- ld_rd_idx_i  in  5  destination register
- flush_i  in  1  kill current load
- mem_req_o  out  1  row read request
- mem_req_addr_o  out  64  row address, bits [2:0] always 0
- mem_req_ready_i  in  1  memory accepts request
- mem_rsp_valid_i  in  1  read data valid
- mem_rsp_data_i  in  64  read row
- wb_valid_o  out  1  load result ready for writeback
- wb_ready_i  in  1  writeback consumes result
- wb_data_o  out  64  row (or merged row) for writeback
- wb_byte_en_o  out  2  captured size
- wb_zero_extnd_o  out  1  captured extension select
- wb_row_idx_o  out  3  byte offset inside wb_data_o
- wb_rd_idx_o  out  5  captured destination
- stall_o  out  1  high whenever state!=IDLE

## Operation
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE, DRAIN.
- IDLE: on ld_valid_i, register addr, size, extnd, rd_idx; compute split = row_idx + size > 8 (size 1/2/4/8); go to REQ0.
- REQ0: mem_req_o=1, addr={a[63:3],3'b0}. On mem_req_ready_i, go to RSP0.
- RSP0: on mem_rsp_valid_i, capture row0. If split, go to REQ1; otherwise go to DONE.
- REQ1: mem_req_o=1, addr=row0 addr+8, modulo 2^64 (wraps to 0). On ready, go to RSP1.
- RSP1: on mem_rsp_valid_i, capture row1; go to DONE.
- DONE: wb_valid_o=1; outputs held stable until wb_ready_i, then go to IDLE.
- Non-split result: wb_data_o=row0, wb_row_idx_o=a[2:0].
- Split result: wb_data_o = low 64 bits of ({row1,row0} >> 8*a[2:0]); wb_row_idx_o=0.
- Flush handling, by state:
  - REQ0, REQ1 or DONE: go to IDLE next cycle, no writeback. A same-cycle request handshake in REQ* counts as issued, so go to DRAIN instead.
  - RSP0 or RSP1: go to DRAIN. In DRAIN, wait for mem_rsp_valid_i, discard it, go to IDLE. A response in the same cycle as the flush goes straight to IDLE.
- At most one memory request outstanding at any time.
- mem_rsp_valid_i outside RSP0/RSP1/DRAIN is ignored.
- Flush in IDLE has no effect; a same-cycle ld_valid_i is not accepted.

## Timing
- Reset values:
  - state=IDLE, so ld_ready_o=1 and stall_o=0.
  - mem_req_o=0, mem_req_addr_o=0, wb_valid_o=0.
  - wb_data_o, wb_byte_en_o, wb_zero_extnd_o, wb_row_idx_o, wb_rd_idx_o all 0.
- All outputs come from registered state; no combinational path from mem_* inputs to mem_req_o.
- Aligned load, zero-wait memory: accept at cycle 0, mem_req_o at 1, response at 2, wb_valid_o at 3. Minimum latency is 3 cycles.
- Split load adds 2 cycles: wb_valid_o at cycle 5 minimum.
- mem_req_o and mem_req_addr_o are held stable until the handshake.
- Reset mid-operation forces IDLE immediately. Any memory response still in flight must be squashed externally.

## Structure
- cpu_consts: add a load_state_t enum and ROW_BYTES=8. Reuse the existing BYTE/HALF_WORD/WORD encodings, with DOUBLE as the fourth code.
- One sub-module, load_row_merge: combinational split merge of {row1,row0} by offset. The FSM stays in mem_load_ctrl.

## Test plan
- Aligned WORD, addr 0x1004, memory returns 0x1122334455667788, ready/valid immediate:
  - mem_req_addr_o=0x1000.
  - wb_valid_o at cycle 3 with wb_data_o=0x1122334455667788, wb_row_idx_o=4.
- Split WORD, addr 0x1006, rows 0xAABB000000000000 then 0x000000000000CCDD:
  - request addresses 0x1000 then 0x1008.
  - wb_data_o low 32 bits = 0xCCDDAABB, wb_row_idx_o=0.
- Backpressure: mem_req_ready_i low for 4 cycles, then wb_ready_i low for 3 cycles:
  - request and write-back outputs stable throughout.
  - exactly one request and one write-back.
- Flush in RSP0, response arrives 2 cycles later:
  - DRAIN absorbs the response, no wb_valid_o.
  - ld_ready_o returns 1 the cycle after the response.
- Split DOUBLE at 0xFFFFFFFFFFFFFFFC: second request address is 0x0000000000000000.
- Async reset asserted during RSP1: all outputs return to reset values with no clock edge; ld_ready_o=1.
